// File: rtl/clk_set_ctrl.sv
// Time-setting controller: RUN/SET/FIX mode FSM, per-digit BCD edit with limits,
// hour-digit clamp sequence, and blink mask generation for the edited position.
module clk_set_ctrl #(
  parameter logic [25:0] CNT_BLINK_MAX = 26'd24_999_999,
  parameter logic [3:0]  DIGIT_MAX_S_H = 4'd5,
  parameter logic [3:0]  DIGIT_MAX_M_H = 4'd5,
  parameter logic [3:0]  DIGIT_MAX_H_H = 4'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_shift,
  input  logic       key_inc,
  output logic       work_en,
  output logic [2:0] set_pos,
  output logic [3:0] set_data,
  output logic       set_flag,
  output logic [5:0] blink_pos
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_SET = 2'd1,
    ST_FIX = 2'd2
  } state_t;

  typedef logic [5:0][3:0] digits_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  fix_step_r, fix_step_nxt_s;
  digits_t     digit_r, digit_nxt_s;
  logic [25:0] blink_cnt_r, blink_cnt_nxt_s;
  logic        blink_phase_r, blink_phase_nxt_s;
  logic        work_en_nxt_s;
  logic [2:0]  set_pos_nxt_s;
  logic [3:0]  set_data_nxt_s;
  logic        set_flag_nxt_s;
  logic [5:0]  blink_pos_nxt_s;
  logic [3:0]  cur_digit_s;
  logic [3:0]  new_digit_s;

  function automatic logic [3:0] get_digit(input digits_t d, input logic [2:0] pos);
    case (pos)
      3'd0:    get_digit = d[0];
      3'd1:    get_digit = d[1];
      3'd2:    get_digit = d[2];
      3'd3:    get_digit = d[3];
      3'd4:    get_digit = d[4];
      3'd5:    get_digit = d[5];
      default: get_digit = 4'd0;
    endcase
  endfunction

  function automatic digits_t put_digit(input digits_t d, input logic [2:0] pos,
                                        input logic [3:0] v);
    put_digit = d;
    case (pos)
      3'd0:    put_digit[0] = v;
      3'd1:    put_digit[1] = v;
      3'd2:    put_digit[2] = v;
      3'd3:    put_digit[3] = v;
      3'd4:    put_digit[4] = v;
      3'd5:    put_digit[5] = v;
      default: put_digit = d;
    endcase
  endfunction

  // h_l is limited to 3 only when the hour tens digit reads 2 (20..23 h)
  function automatic logic [3:0] digit_max(input logic [2:0] pos, input logic [3:0] h_h);
    case (pos)
      3'd0:    digit_max = 4'd9;
      3'd1:    digit_max = DIGIT_MAX_S_H;
      3'd2:    digit_max = 4'd9;
      3'd3:    digit_max = DIGIT_MAX_M_H;
      3'd4:    digit_max = (h_h == 4'd2) ? 4'd3 : 4'd9;
      3'd5:    digit_max = DIGIT_MAX_H_H;
      default: digit_max = 4'd9;
    endcase
  endfunction

  assign cur_digit_s = get_digit(digit_r, set_pos);
  assign new_digit_s = (cur_digit_s >= digit_max(set_pos, digit_r[5])) ? 4'd0
                                                                      : cur_digit_s + 4'd1;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      fix_step_r <= 2'd0;
    end else begin
      state_r    <= state_nxt_s;
      fix_step_r <= fix_step_nxt_s;
    end
  end

  // Next-state, digit editing, blink timing and output values
  always_comb begin
    state_nxt_s       = state_r;
    fix_step_nxt_s    = fix_step_r;
    digit_nxt_s       = digit_r;
    blink_cnt_nxt_s   = blink_cnt_r;
    blink_phase_nxt_s = blink_phase_r;
    work_en_nxt_s     = work_en;
    set_pos_nxt_s     = set_pos;
    set_data_nxt_s    = set_data;
    set_flag_nxt_s    = 1'b0;

    if (state_r != ST_RUN) begin
      if (blink_cnt_r == CNT_BLINK_MAX) begin
        blink_cnt_nxt_s   = 26'd0;
        blink_phase_nxt_s = ~blink_phase_r;
      end else begin
        blink_cnt_nxt_s = blink_cnt_r + 26'd1;
      end
    end else begin
      blink_cnt_nxt_s = blink_cnt_r;
    end

    case (state_r)
      ST_RUN: begin
        work_en_nxt_s = 1'b1;
        if (key_mode) begin
          state_nxt_s       = ST_SET;
          work_en_nxt_s     = 1'b0;
          set_pos_nxt_s     = 3'd0;
          digit_nxt_s       = '0;
          blink_cnt_nxt_s   = 26'd0;
          blink_phase_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_SET: begin
        if (key_mode) begin
          state_nxt_s   = ST_RUN;
          work_en_nxt_s = 1'b1;
        end else if (key_shift) begin
          set_pos_nxt_s     = (set_pos == 3'd5) ? 3'd0 : set_pos + 3'd1;
          blink_cnt_nxt_s   = 26'd0;
          blink_phase_nxt_s = 1'b1;
        end else if (key_inc) begin
          digit_nxt_s    = put_digit(digit_r, set_pos, new_digit_s);
          set_data_nxt_s = new_digit_s;
          set_flag_nxt_s = 1'b1;
          if ((set_pos == 3'd5) && (new_digit_s == 4'd2) && (digit_r[4] > 4'd3)) begin
            state_nxt_s    = ST_FIX;
            fix_step_nxt_s = 2'd0;
          end else begin
            state_nxt_s = ST_SET;
          end
        end else begin
          state_nxt_s = ST_SET;
        end
      end
      // Keys are dropped here: one quiet cycle, the h_l clamp strobe, then back to h_h
      ST_FIX: begin
        case (fix_step_r)
          2'd0: begin
            fix_step_nxt_s = 2'd1;
          end
          2'd1: begin
            digit_nxt_s    = put_digit(digit_r, 3'd4, 4'd3);
            set_pos_nxt_s  = 3'd4;
            set_data_nxt_s = 4'd3;
            set_flag_nxt_s = 1'b1;
            fix_step_nxt_s = 2'd2;
          end
          2'd2: begin
            set_pos_nxt_s  = 3'd5;
            fix_step_nxt_s = 2'd0;
            state_nxt_s    = ST_SET;
          end
          default: begin
            fix_step_nxt_s = 2'd0;
            state_nxt_s    = ST_SET;
          end
        endcase
      end
      default: begin
        state_nxt_s    = ST_RUN;
        fix_step_nxt_s = 2'd0;
        work_en_nxt_s  = 1'b1;
      end
    endcase

    if ((state_nxt_s != ST_RUN) && blink_phase_nxt_s) begin
      blink_pos_nxt_s = 6'd1 << set_pos_nxt_s;
    end else begin
      blink_pos_nxt_s = 6'd0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_r       <= '0;
      blink_cnt_r   <= 26'd0;
      blink_phase_r <= 1'b0;
      work_en       <= 1'b1;
      set_pos       <= 3'd0;
      set_data      <= 4'd0;
      set_flag      <= 1'b0;
      blink_pos     <= 6'd0;
    end else begin
      digit_r       <= digit_nxt_s;
      blink_cnt_r   <= blink_cnt_nxt_s;
      blink_phase_r <= blink_phase_nxt_s;
      work_en       <= work_en_nxt_s;
      set_pos       <= set_pos_nxt_s;
      set_data      <= set_data_nxt_s;
      set_flag      <= set_flag_nxt_s;
      blink_pos     <= blink_pos_nxt_s;
    end
  end

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Table-driven bench for clk_set_ctrl with a queue scoreboard and hand-written
// reset-in-SET / reset-in-FIX sequences; blink half-period shortened to 10 clk.
module tb_clk_set_ctrl;

  localparam logic [2:0] K_NONE  = 3'b000;
  localparam logic [2:0] K_MODE  = 3'b100;
  localparam logic [2:0] K_SHIFT = 3'b010;
  localparam logic [2:0] K_INC   = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_mode, key_shift, key_inc;
  logic       work_en;
  logic [2:0] set_pos;
  logic [3:0] set_data;
  logic       set_flag;
  logic [5:0] blink_pos;

  typedef struct packed {
    logic       we;
    logic [2:0] pos;
    logic [3:0] data;
    logic       flag;
    logic [5:0] blink;
  } exp_t;

  typedef struct packed {
    logic [2:0] keys;
    logic       we;
    logic [2:0] pos;
    logic [3:0] data;
    logic       flag;
    logic       brst;
  } vec_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bk = 0;

  clk_set_ctrl #(.CNT_BLINK_MAX(26'd9)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_shift(key_shift),
    .key_inc(key_inc), .work_en(work_en), .set_pos(set_pos), .set_data(set_data),
    .set_flag(set_flag), .blink_pos(blink_pos)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] keys, input logic we, input logic [2:0] pos,
                              input logic [3:0] data, input logic flag, input logic brst);
    vec_t v;
    v.keys = keys; v.we = we; v.pos = pos; v.data = data; v.flag = flag; v.brst = brst;
    return v;
  endfunction

  task automatic compare(input exp_t e, input string tag);
    exp_t a;
    a = {work_en, set_pos, set_data, set_flag, blink_pos};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got we=%0b pos=%0d data=%0d flag=%0b blink=%b, want we=%0b pos=%0d data=%0d flag=%0b blink=%b",
               tag, a.we, a.pos, a.data, a.flag, a.blink, e.we, e.pos, e.data, e.flag, e.blink);
    end
  endtask

  // Drive one cycle of keys, queue the expected outputs, check them 1 ns after the edge
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    {key_mode, key_shift, key_inc} = v.keys;
    if (v.brst) bk = 0;
    else bk++;
    e.we    = v.we;
    e.pos   = v.pos;
    e.data  = v.data;
    e.flag  = v.flag;
    e.blink = (!v.we && ((bk / 10) % 2 == 0)) ? (6'd1 << v.pos) : 6'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    {key_mode, key_shift, key_inc} = K_NONE;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got nothing to compare, want one entry", tag);
    end else begin
      compare(exp_q.pop_front(), tag);
    end
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  task automatic check_reset_state(input string tag);
    exp_t e;
    e = {1'b1, 3'd0, 4'd0, 1'b0, 6'd0};
    compare(e, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    {key_mode, key_shift, key_inc} = K_NONE;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // RUN ignores shift/inc; enter SET; ten incs at s_l; six shifts
    tbl.push_back(mk(K_NONE,  1'b1, 3'd0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(K_SHIFT, 1'b1, 3'd0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(K_INC,   1'b1, 3'd0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(K_MODE,  1'b0, 3'd0, 4'd0, 1'b0, 1'b1));
    for (int n = 1; n <= 10; n++) begin
      tbl.push_back(mk(K_INC,  1'b0, 3'd0, 4'(n % 10), 1'b1, 1'b0));
      tbl.push_back(mk(K_NONE, 1'b0, 3'd0, 4'(n % 10), 1'b0, 1'b0));
    end
    for (int n = 1; n <= 6; n++) begin
      tbl.push_back(mk(K_SHIFT, 1'b0, 3'(n % 6), 4'd0, 1'b0, 1'b1));
      tbl.push_back(mk(K_NONE,  1'b0, 3'(n % 6), 4'd0, 1'b0, 1'b0));
    end
    // h_l to 7, then h_h 0->1->2 triggers the clamp sequence
    for (int n = 1; n <= 4; n++) begin
      tbl.push_back(mk(K_SHIFT, 1'b0, 3'(n), 4'd0, 1'b0, 1'b1));
      tbl.push_back(mk(K_NONE,  1'b0, 3'(n), 4'd0, 1'b0, 1'b0));
    end
    for (int n = 1; n <= 7; n++) begin
      tbl.push_back(mk(K_INC,  1'b0, 3'd4, 4'(n), 1'b1, 1'b0));
      tbl.push_back(mk(K_NONE, 1'b0, 3'd4, 4'(n), 1'b0, 1'b0));
    end
    tbl.push_back(mk(K_SHIFT, 1'b0, 3'd5, 4'd7, 1'b0, 1'b1));
    tbl.push_back(mk(K_NONE,  1'b0, 3'd5, 4'd7, 1'b0, 1'b0));
    tbl.push_back(mk(K_INC,   1'b0, 3'd5, 4'd1, 1'b1, 1'b0));
    tbl.push_back(mk(K_NONE,  1'b0, 3'd5, 4'd1, 1'b0, 1'b0));
    tbl.push_back(mk(K_INC,   1'b0, 3'd5, 4'd2, 1'b1, 1'b0));
    tbl.push_back(mk(K_INC,   1'b0, 3'd5, 4'd2, 1'b0, 1'b0));
    tbl.push_back(mk(K_INC,   1'b0, 3'd4, 4'd3, 1'b1, 1'b0));
    tbl.push_back(mk(K_SHIFT, 1'b0, 3'd5, 4'd3, 1'b0, 1'b0));
    tbl.push_back(mk(K_NONE,  1'b0, 3'd5, 4'd3, 1'b0, 1'b0));
    // walk to h_l: clamped to 3 with limit 3, so one inc wraps to 0
    for (int n = 1; n <= 5; n++) begin
      tbl.push_back(mk(K_SHIFT, 1'b0, 3'(n - 1), 4'd3, 1'b0, 1'b1));
      tbl.push_back(mk(K_NONE,  1'b0, 3'(n - 1), 4'd3, 1'b0, 1'b0));
    end
    tbl.push_back(mk(K_INC,   1'b0, 3'd4, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(K_NONE,  1'b0, 3'd4, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(K_SHIFT, 1'b0, 3'd5, 4'd0, 1'b0, 1'b1));
    tbl.push_back(mk(K_NONE,  1'b0, 3'd5, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(K_INC,   1'b0, 3'd5, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(K_NONE,  1'b0, 3'd5, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(K_SHIFT, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1));
    tbl.push_back(mk(K_NONE,  1'b0, 3'd0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(K_SHIFT, 1'b0, 3'd1, 4'd0, 1'b0, 1'b1));
    tbl.push_back(mk(K_NONE,  1'b0, 3'd1, 4'd0, 1'b0, 1'b0));
    for (int n = 1; n <= 6; n++) begin
      tbl.push_back(mk(K_INC,  1'b0, 3'd1, 4'(n % 6), 1'b1, 1'b0));
      tbl.push_back(mk(K_NONE, 1'b0, 3'd1, 4'(n % 6), 1'b0, 1'b0));
    end
    // priority: shift beats inc, mode beats inc
    tbl.push_back(mk(K_SHIFT | K_INC, 1'b0, 3'd2, 4'd0, 1'b0, 1'b1));
    tbl.push_back(mk(K_NONE,          1'b0, 3'd2, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(K_MODE | K_INC,  1'b1, 3'd2, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(K_NONE,          1'b1, 3'd2, 4'd0, 1'b0, 1'b0));
    run_table("main");

    // Blink at m_h over 25 idle cycles, then asynchronous reset mid-SET
    apply(mk(K_MODE, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1), "blink_enter");
    for (int n = 1; n <= 3; n++) apply(mk(K_SHIFT, 1'b0, 3'(n), 4'd0, 1'b0, 1'b1), "blink_shift");
    for (int n = 1; n <= 25; n++) apply(mk(K_NONE, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0), $sformatf("blink_idle%0d", n));
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_mid_set");
    @(posedge clk);
    #1 check_reset_state("rst_mid_set_hold");
    rst_n = 1'b1;
    apply(mk(K_MODE, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1), "first_key_after_rst");
    checks++;
    if (blink_pos !== 6'b000001) begin
      errors++;
      $display("FAIL first_blink: got %b want 000001", blink_pos);
    end

    // Drive into FIX (h_l=4, h_h -> 2), then reset during the quiet cycle
    for (int n = 1; n <= 4; n++) apply(mk(K_SHIFT, 1'b0, 3'(n), 4'd0, 1'b0, 1'b1), "fix_shift");
    for (int n = 1; n <= 4; n++) begin
      apply(mk(K_INC,  1'b0, 3'd4, 4'(n), 1'b1, 1'b0), "fix_inc");
      apply(mk(K_NONE, 1'b0, 3'd4, 4'(n), 1'b0, 1'b0), "fix_idle");
    end
    apply(mk(K_SHIFT, 1'b0, 3'd5, 4'd4, 1'b0, 1'b1), "fix_to_hh");
    apply(mk(K_INC,   1'b0, 3'd5, 4'd1, 1'b1, 1'b0), "fix_hh1");
    apply(mk(K_NONE,  1'b0, 3'd5, 4'd1, 1'b0, 1'b0), "fix_hh1_idle");
    apply(mk(K_INC,   1'b0, 3'd5, 4'd2, 1'b1, 1'b0), "fix_hh2");
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_mid_fix");
    @(posedge clk);
    #1 check_reset_state("rst_mid_fix_hold");
    rst_n = 1'b1;
    apply(mk(K_MODE, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1), "reenter_set");
    apply(mk(K_INC,  1'b0, 3'd0, 4'd1, 1'b1, 1'b0), "reenter_inc");
    apply(mk(K_MODE, 1'b1, 3'd0, 4'd1, 1'b0, 1'b0), "back_to_run");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
